// File: rtl/avalon_gpio_edge_if.sv
// Avalon-MM slave bus bundle for avalon_gpio_edge.
// Signals:
//   address    - 3-bit register word address
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - 32-bit write data
//   readdata   - 32-bit registered read data (driven by the slave)
interface avalon_gpio_edge_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_gpio_edge.sv
// avalon_gpio_edge: parametrised GPIO peripheral on a 32-bit Avalon-MM slave.
// Provides per-bit output drive/direction, synchronised and optionally
// debounced inputs, per-bit edge detection (rising/falling/both) into a
// write-1-to-clear capture register, atomic output set/clear and a level irq.
//
// Ports:
//   clk      - system clock, all logic on rising edge
//   reset_n  - synchronous active-low reset
//   bus      - Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  - asynchronous pad inputs
//   out_port - output data register
//   oe_port  - per-bit output enable (direction register)
//   irq      - OR of (edge capture & irq mask)
//
// Register map: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C),
//               4 OUT_SET, 5 OUT_CLR, 6 EDGE_MODE (2 bits/GPIO), 7 reserved.
module avalon_gpio_edge #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_gpio_edge_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     oe_port,
  output logic                 irq
);

  localparam int MW = 2 * WIDTH;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_SET     = 3'd4;
  localparam logic [2:0] ADDR_CLR     = 3'd5;
  localparam logic [2:0] ADDR_MODE    = 3'd6;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d1_reg;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [MW-1:0]    mode_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] cap_next;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [MW-1:0]    wd_mode;
  logic             unused_wd;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  // Bits at or above WIDTH (2*WIDTH for EDGE_MODE) are dropped here.
  assign wd      = bus.writedata[WIDTH-1:0];
  assign wd_mode = bus.writedata[MW-1:0];
  assign unused_wd = ^bus.writedata;

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
    end else begin
      sync_reg[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce: filt only follows synced once it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  // ---------------------------------------------------------------------
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt = synced;
  end else begin : g_debounce
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [15:0] cnt_reg;
      logic        filt_reg;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (synced[gi] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          filt_reg <= synced[gi];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign filt[gi] = filt_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Edge detection and mode selection
  // ---------------------------------------------------------------------
  assign rise = filt & ~filt_d1_reg;
  assign fall = ~filt & filt_d1_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign edge_hit[gi] = (mode_reg[2*gi]   & rise[gi]) |
                          (mode_reg[2*gi+1] & fall[gi]);
  end

  // Clear first, then OR in new edges so an edge coincident with a W1C
  // write is never lost.
  assign cap_clr  = (wr_en && bus.address == ADDR_CAPTURE) ? wd : '0;
  assign cap_next = (cap_reg & ~cap_clr) | edge_hit;

  // ---------------------------------------------------------------------
  // Read mux (registered every cycle from the current address)
  // ---------------------------------------------------------------------
  always_comb begin
    readdata_next = '0;
    case (bus.address)
      ADDR_DATA:    readdata_next[WIDTH-1:0] = filt;
      ADDR_DIR:     readdata_next[WIDTH-1:0] = dir_reg;
      ADDR_MASK:    readdata_next[WIDTH-1:0] = mask_reg;
      ADDR_CAPTURE: readdata_next[WIDTH-1:0] = cap_reg;
      ADDR_MODE:    readdata_next[MW-1:0]    = mode_reg;
      default:      readdata_next            = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_reg      <= RESET_OUT;
      dir_reg      <= '0;
      mask_reg     <= '0;
      mode_reg     <= '0;
      cap_reg      <= '0;
      filt_d1_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      filt_d1_reg  <= filt;
      cap_reg      <= cap_next;
      readdata_reg <= readdata_next;
      if (wr_en) begin
        case (bus.address)
          ADDR_DATA: out_reg  <= wd;
          ADDR_DIR:  dir_reg  <= wd;
          ADDR_MASK: mask_reg <= wd;
          ADDR_SET:  out_reg  <= out_reg | wd;
          ADDR_CLR:  out_reg  <= out_reg & ~wd;
          ADDR_MODE: mode_reg <= wd_mode;
          default:   ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_reg;
  assign out_port     = out_reg;
  assign oe_port      = dir_reg;
  assign irq          = |(cap_reg & mask_reg);

endmodule

// File: doc/avalon_gpio_edge.md
# avalon_gpio_edge

Parametrised general-purpose I/O peripheral for the Nios II system, on a 32-bit Avalon-MM slave. It adds over the fixed 4-bit input PIO:
- configurable width;
- per-bit output drive and direction;
- input synchroniser and optional debounce;
- per-bit edge mode (rising/falling/both);
- write-1-to-clear edge capture;
- atomic output set/clear.

The level-sensitive `irq` goes to the CPU interrupt controller.

## Interface
- `WIDTH`, 8 — number of GPIO bits, 1..16.
- `SYNC_STAGES`, 2 — input synchroniser flops, 2..4.
- `DEBOUNCE_CYCLES`, 0 — stable cycles required before filtered input changes; 0 bypasses the filter; max 65535.
- `RESET_OUT`, 0 — reset value of output data register, `WIDTH` bits.

Ports:
- `clk`  in  1  — system clock; all logic on rising edge.
- `reset_n`  in  1  — reset is synchronous and active-low.
- `address`  in  3  — register word address.
- `chipselect`  in  1  — slave select.
- `write_n`  in  1  — active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  — write data.
- `readdata`  out  32  — registered read data.
- `in_port`  in  `WIDTH`  — asynchronous pad inputs.
- `out_port`  out  `WIDTH`  — output data register.
- `oe_port`  out  `WIDTH`  — per-bit output enable; equals direction register.
- `irq`  out  1  — OR of (edge_capture & irq_mask).

## Operation
Register map (unused upper bits read 0, ignored on write):
- 0 DATA — read: filtered input; write: output data register.
- 1 DIR — 1 = output.
- 2 IRQ_MASK.
- 3 EDGE_CAPTURE — read: capture bits; write: 1 clears that bit, 0 leaves it unchanged.
- 4 OUT_SET — write: data_out |= wd. Read returns 0.
- 5 OUT_CLR — write: data_out &= ~wd. Read returns 0.
- 6 EDGE_MODE — 2 bits per GPIO bit i at [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
- 7 reserved — reads 0, writes ignored.

Input path:
- `in_port` → `SYNC_STAGES` flop chain → synced → debounce → filt.
- filt_d1 is filt delayed one cycle.
- rise = filt & ~filt_d1; fall = ~filt & filt_d1.

Debounce, per bit, when `DEBOUNCE_CYCLES` > 0:
- 16-bit counter.
- If synced == filt: counter = 0.
- Else if counter == `DEBOUNCE_CYCLES`-1: filt <= synced, counter = 0.
- Else counter++.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches filt.

Edge capture:
- Bit i sets when its mode-selected edge occurs.
- A W1C write clears it.
- Simultaneous set and clear on the same bit: set wins, so an edge is never lost.

Other rules:
- `irq` = |(edge_capture & irq_mask), combinational from registers.
- Writes to mask, mode or DIR take effect the cycle after the write.
- The input path runs regardless of DIR: an output bit still reads and captures its pad value.

Reset while `reset_n` low at a clock edge:
- data_out = `RESET_OUT`.
- DIR, mask, mode, capture, sync chain, filt, filt_d1, counters and `readdata` = 0.
- Result: `irq` = 0, `oe_port` = 0.
- Reset mid-debounce discards count progress.

## Timing
- Reads: `readdata` is registered every cycle from the current `address`. Data is valid on the edge after address is presented (1-cycle read latency, no wait states).
- Writes complete on the edge where `chipselect` & ~`write_n` is sampled. `out_port` and `oe_port` change on that edge.
- Input latency, `DEBOUNCE_CYCLES`=0: a change on `in_port` before edge 1 appears in filt after edge `SYNC_STAGES`. The capture bit and `irq` assert after edge `SYNC_STAGES`+1.
- With debounce N: add N edges.
- DATA read reflects filt, not raw input.
- A W1C write and an edge on the same cycle leave the bit set; `irq` stays high.
- Out-of-range bits (≥ `WIDTH`) in any write are ignored.

## Test plan
- **Reset values:** `RESET_OUT`=0x5A, `WIDTH`=8; hold `reset_n` low 3 clocks with `in_port`=0xFF → `out_port`=0x5A, `oe_port`=0, `readdata`=0, `irq`=0. After release, DATA reads 0xFF after `SYNC_STAGES`+2 cycles.
- **Rising edge and W1C:** mode=0x0001 (bit0 rising), mask=0x01; `in_port`[0] 0→1 → `irq` high exactly `SYNC_STAGES`+1 edges later; EDGE_CAPTURE reads 0x01. Write 0x02 to EDGE_CAPTURE → still 0x01. Write 0x01 → 0, `irq` low next cycle.
- **Falling/both modes:** mode bit1=10, bit2=11; toggle bit1 1→0 and bit2 0→1→0 → capture = 0x06. Rising on bit1 alone → no capture.
- **Set/clear race:** schedule the W1C write to bit0 on the same cycle as a new rising edge → bit0 remains 1, `irq` stays high.
- **Debounce:** `DEBOUNCE_CYCLES`=4; pulse `in_port`[3] high for 3 cycles → no filt change, no capture. Hold 4 cycles → filt changes `SYNC_STAGES`+4 edges after the input, capture sets one edge later.
- **Atomic output:** write DATA=0xF0, OUT_SET=0x03, OUT_CLR=0x80 → `out_port`=0x73. DIR=0x0F → `oe_port`=0x0F. Reads of OUT_SET and OUT_CLR return 0.
